// File: rtl/ov5640_iic_slave.sv
// I2C register-access slave for the OV5640 SCCB map: 16-bit register pointer, 8-bit data.
// SCL/SDA are oversampled by sclk; SDA is open-drain and is only ever pulled low.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | bus ignored until START
// DEV       | shifting in device address + R/W
// ACK_DEV   | acknowledging device address
// ADDR_H    | shifting in register pointer high byte
// ACK_H     | acknowledging high byte
// ADDR_L    | shifting in register pointer low byte
// ACK_L     | acknowledging low byte, pointer loaded at end
// WDATA     | shifting in write data
// ACK_W     | acknowledging write data, pointer incremented at end
// RDATA     | driving read data, MSB first
// MACK      | master ACK/NACK slot after a read byte
// WAIT_STOP | not addressed or read ended, wait for STOP/START
module ov5640_iic_slave #(
    parameter logic [6:0] DEV_ID = 7'h3C
) (
    input  logic        sclk,
    input  logic        s_rst,
    input  logic        iic_scl,
    inout  wire         iic_sda,
    output logic [15:0] reg_addr,
    output logic        reg_wr,
    output logic [7:0]  reg_wdata,
    output logic        reg_rd,
    input  logic [7:0]  reg_rdata,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, DEV, ACK_DEV, ADDR_H, ACK_H, ADDR_L, ACK_L,
        WDATA, ACK_W, RDATA, MACK, WAIT_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  scl_sync_q, scl_sync_d;
    logic [2:0]  sda_sync_q, sda_sync_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  addr_h_q, addr_h_d;
    logic        rw_q, rw_d;
    logic        sda_oe_q, sda_oe_d;
    logic [15:0] reg_addr_q, reg_addr_d;
    logic        reg_wr_q, reg_wr_d;
    logic [7:0]  reg_wdata_q, reg_wdata_d;
    logic        reg_rd_q, reg_rd_d;
    logic        rd_pend_q, rd_pend_d;
    logic        busy_q, busy_d;

    logic        scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]  rx_byte;

    // bit 1 is the synchronized level, bit 2 its previous value for edge detection
    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_sync_q[2];
    assign scl_fall  = ~scl_s & scl_sync_q[2];
    assign start_det = scl_s & scl_sync_q[2] & sda_sync_q[2] & ~sda_s;
    assign stop_det  = scl_s & scl_sync_q[2] & ~sda_sync_q[2] & sda_s;
    assign rx_byte   = {shift_q[6:0], sda_s};

    assign iic_sda   = sda_oe_q ? 1'b0 : 1'bz;
    assign reg_addr  = reg_addr_q;
    assign reg_wr    = reg_wr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_rd    = reg_rd_q;
    assign busy      = busy_q;

    always_comb begin
        scl_sync_d  = {scl_sync_q[1:0], iic_scl};
        sda_sync_d  = {sda_sync_q[1:0], iic_sda};
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        addr_h_d    = addr_h_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wr_d    = 1'b0;
        reg_wdata_d = reg_wdata_q;
        reg_rd_d    = 1'b0;
        rd_pend_d   = reg_rd_q;
        busy_d      = busy_q;

        // read data arrives the cycle after the request
        if (rd_pend_q) shift_d = reg_rdata;

        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = DEV;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                DEV, ADDR_H, ADDR_L, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            case (state_q)
                                DEV: begin
                                    if (rx_byte[7:1] == DEV_ID) begin
                                        state_d = ACK_DEV;
                                        busy_d  = 1'b1;
                                        rw_d    = rx_byte[0];
                                    end else begin
                                        state_d = WAIT_STOP;
                                        busy_d  = 1'b0;
                                    end
                                end
                                ADDR_H: begin
                                    addr_h_d = rx_byte;
                                    state_d  = ACK_H;
                                end
                                ADDR_L:  state_d = ACK_L;
                                default: begin
                                    reg_wr_d    = 1'b1;
                                    reg_wdata_d = rx_byte;
                                    state_d     = ACK_W;
                                end
                            endcase
                        end
                    end
                end
                ACK_DEV, ACK_H, ACK_L, ACK_W: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            case (state_q)
                                ACK_DEV: state_d = ADDR_H;
                                ACK_H:   state_d = ADDR_L;
                                ACK_L: begin
                                    reg_addr_d = {addr_h_q, shift_q};
                                    state_d    = WDATA;
                                end
                                default: begin
                                    reg_addr_d = reg_addr_q + 16'd1;
                                    state_d    = WDATA;
                                end
                            endcase
                        end
                    end else if (scl_rise && state_q == ACK_DEV && rw_q && sda_oe_q) begin
                        // read: fetch now, the ACK slot is released by RDATA's first fall
                        reg_rd_d  = 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = RDATA;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_oe_d = ~shift_q[7];
                        end else if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = MACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                MACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            reg_addr_d = reg_addr_q + 16'd1;
                            reg_rd_d   = 1'b1;
                            bit_cnt_d  = 4'd0;
                            state_d    = RDATA;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q     <= IDLE;
            scl_sync_q  <= 3'b111;
            sda_sync_q  <= 3'b111;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            addr_h_q    <= 8'd0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= 16'd0;
            reg_wr_q    <= 1'b0;
            reg_wdata_q <= 8'd0;
            reg_rd_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_h_q    <= addr_h_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wr_q    <= reg_wr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_rd_q    <= reg_rd_d;
            rd_pend_q   <= rd_pend_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_ov5640_iic_slave.sv
// Bench for ov5640_iic_slave: bit-banged I2C master, register-file model and
// a transaction-level reference of pointer/ACK/strobe behaviour.
`timescale 1ns/1ps
module tb_ov5640_iic_slave;

    localparam logic [6:0] ID = 7'h3C;
    localparam time        Q  = 40ns;

    logic        sclk = 1'b0;
    logic        s_rst = 1'b1;
    logic        iic_scl = 1'b1;
    logic        sda_m = 1'b1;
    wire         iic_sda;
    logic [15:0] reg_addr;
    logic        reg_wr;
    logic [7:0]  reg_wdata;
    logic        reg_rd;
    logic [7:0]  reg_rdata = 8'd0;
    logic        busy;

    pullup (iic_sda);
    assign iic_sda = sda_m ? 1'bz : 1'b0;

    ov5640_iic_slave #(.DEV_ID(ID)) dut (
        .sclk(sclk), .s_rst(s_rst), .iic_scl(iic_scl), .iic_sda(iic_sda),
        .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
        .reg_rd(reg_rd), .reg_rdata(reg_rdata), .busy(busy)
    );

    always #5 sclk = ~sclk;

    logic [7:0]  rf      [0:65535];
    logic [7:0]  mdl_mem [0:65535];
    logic [23:0] wr_q[$];
    int          rd_cnt = 0;
    logic [15:0] m_ptr = 16'd0;
    int          n_chk = 0;
    int          n_err = 0;

    // register file seen by the DUT, plus strobe monitor
    always @(negedge sclk) begin
        if (reg_wr) begin
            wr_q.push_back({reg_addr, reg_wdata});
            rf[reg_addr] = reg_wdata;
        end
        if (reg_rd) begin
            rd_cnt++;
            reg_rdata = rf[reg_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic bus();
        return (iic_sda === 1'b0) ? 1'b0 : 1'b1;
    endfunction

    task automatic bus_bit(input logic v, output logic smp);
        #Q sda_m = v;
        #Q iic_scl = 1'b1;
        #Q smp = bus();
        #Q iic_scl = 1'b0;
    endtask

    task automatic send_start();
        if (iic_scl == 1'b0) begin
            #Q sda_m = 1'b1;
            #Q iic_scl = 1'b1;
        end
        #Q sda_m = 1'b0;
        #Q iic_scl = 1'b0;
    endtask

    task automatic send_stop();
        #Q sda_m = 1'b0;
        #Q iic_scl = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(~mack, s);
    endtask

    // Write-direction transaction: dev byte then payload; first two payload
    // bytes form the pointer, the rest are data written at pointer++.
    task automatic do_write(input logic [7:0] dev, input logic [7:0] d[$], input bit stop);
        logic        ack;
        bit          ok;
        logic [23:0] exp_q[$];
        wr_q.delete();
        rd_cnt = 0;
        ok = (dev[7:1] == ID) && !dev[0];
        send_start();
        wr_byte(dev, ack);
        check("dev_ack", ack, ok);
        check("busy_dev", busy, ok);
        for (int i = 0; i < d.size(); i++) begin
            wr_byte(d[i], ack);
            check("data_ack", ack, ok);
            if (ok && i == 1) m_ptr = {d[0], d[1]};
            if (ok && i >= 2) begin
                exp_q.push_back({m_ptr, d[i]});
                mdl_mem[m_ptr] = d[i];
                m_ptr = m_ptr + 16'd1;
            end
        end
        if (stop) begin
            send_stop();
            #Q;
            check("busy_stop", busy, 0);
        end else begin
            #Q;
        end
        check("wr_cnt", wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check("wr_evt", wr_q[i], exp_q[i]);
        check("wr_rd_cnt", rd_cnt, 0);
        check("wr_ptr", reg_addr, m_ptr);
    endtask

    // Read transaction from the current pointer: n bytes, master ACKs all but the last.
    task automatic do_read(input int n, input bit extra);
        logic       ack;
        logic [7:0] d;
        wr_q.delete();
        rd_cnt = 0;
        send_start();
        wr_byte({ID, 1'b1}, ack);
        check("rdev_ack", ack, 1);
        check("busy_rdev", busy, 1);
        for (int i = 0; i < n; i++) begin
            rd_byte(i < n - 1, d);
            check("rdata", d, mdl_mem[m_ptr]);
            if (i < n - 1) m_ptr = m_ptr + 16'd1;
        end
        if (extra) begin
            rd_byte(1'b0, d);
            check("wait_stop_rel", d, 8'hFF);
        end
        send_stop();
        #Q;
        check("busy_rstop", busy, 0);
        check("rd_cnt", rd_cnt, n);
        check("rd_wr_cnt", wr_q.size(), 0);
        check("rd_ptr", reg_addr, m_ptr);
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [7:0]  d;
        logic        s, ack;
        logic [15:0] a;
        int          n;

        for (int i = 0; i < 65536; i++) begin
            rf[i]      = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
            mdl_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
        end
        repeat (5) @(posedge sclk);
        #1 s_rst = 1'b0;
        repeat (3) @(negedge sclk);
        check("rst_addr", reg_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_wr", reg_wr, 0);
        check("rst_rd", reg_rd, 0);
        check("rst_wdata", reg_wdata, 0);
        check("rst_sda", bus(), 1);

        do_write(8'h78, '{8'h30, 8'h08, 8'h82}, 1'b1);
        do_write(8'h78, '{8'h47, 8'h40, 8'h11, 8'h22}, 1'b1);
        rf[16'h300A] = 8'h56;
        mdl_mem[16'h300A] = 8'h56;
        do_write(8'h78, '{8'h30, 8'h0A}, 1'b0);
        do_read(1, 1'b1);
        do_write(8'h42, '{8'h30, 8'h08, 8'h55}, 1'b1);
        do_write(8'h78, '{8'hAB}, 1'b1);
        do_write(8'h78, '{8'hFF, 8'hFF, 8'h01, 8'h02}, 1'b1);
        do_read(3, 1'b0);

        for (int t = 0; t < 30; t++) begin
            q.delete();
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    q.push_back(a[15:8]);
                    q.push_back(a[7:0]);
                    n = $urandom_range(0, 3);
                    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                    do_write({ID, 1'b0}, q, 1'b1);
                end
                1: do_read($urandom_range(1, 3), 1'b0);
                2: begin
                    q.push_back(a[15:8]);
                    q.push_back(a[7:0]);
                    do_write({ID, 1'b0}, q, 1'b0);
                    do_read($urandom_range(1, 3), 1'b0);
                end
                default: begin
                    d = 8'($urandom);
                    if (d[7:1] == ID) d[7] = ~d[7];
                    n = $urandom_range(1, 3);
                    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                    do_write(d, q, 1'b1);
                end
            endcase
        end

        // reset in the middle of a read byte whose leading bits are zero
        do_write(8'h78, '{8'h12, 8'h34, 8'h12}, 1'b1);
        do_write(8'h78, '{8'h12, 8'h34}, 1'b1);
        rd_cnt = 0;
        wr_q.delete();
        send_start();
        wr_byte({ID, 1'b1}, ack);
        check("rr_dev_ack", ack, 1);
        d = mdl_mem[m_ptr];
        bus_bit(1'b1, s);
        check("rr_bit7", s, d[7]);
        #Q;
        check("rr_bit6_drv", bus(), d[6]);
        @(negedge sclk) s_rst = 1'b1;
        @(posedge sclk);
        #1;
        check("rr_sda_rel", bus(), 1);
        check("rr_addr", reg_addr, 0);
        check("rr_busy", busy, 0);
        s_rst = 1'b0;
        m_ptr = 16'd0;
        for (int i = 0; i < 3; i++) begin
            bus_bit(1'b1, s);
            check("rr_ignored", s, 1);
        end
        send_stop();
        #Q;
        check("rr_rd_cnt", rd_cnt, 1);
        check("rr_wr_cnt", wr_q.size(), 0);
        do_read(2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ov5640_iic_slave.md
OV5640_IIC_SLAVE -- requirements
Module: ov5640_iic_slave

Interface
REQ-001 SHALL have parameter DEV_ID, default 7'h3C, the 7-bit device address it responds to (write byte 0x78, read byte 0x79).
REQ-002 SHALL have port sclk, input, 1 bit: the system clock, which oversamples SCL by at least 8x.
REQ-003 SHALL have port s_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port iic_scl, input, 1 bit: bus clock, asynchronous to sclk.
REQ-005 SHALL have port iic_sda, inout, 1 bit: bus data, driven only as 0 or Z.
REQ-006 SHALL have port reg_addr, output, 16 bits: current register pointer.
REQ-007 SHALL have port reg_wr, output, 1 bit: one-cycle write strobe.
REQ-008 SHALL have port reg_wdata, output, 8 bits: write data, valid while reg_wr is high.
REQ-009 SHALL have port reg_rd, output, 1 bit: one-cycle read request.
REQ-010 SHALL have port reg_rdata, input, 8 bits: read data, valid on the sclk cycle after reg_rd.
REQ-011 SHALL have port busy, output, 1 bit: high from an addressed START until STOP or abort.

Function
REQ-012 SHALL pass iic_scl and iic_sda through 2-flop synchronizers; all edge detection SHALL use the synchronized signals (2-3 cycle latency).
REQ-013 SHALL detect START as synced SDA falling while synced SCL is high, and STOP as synced SDA rising while synced SCL is high.
REQ-014 SHALL sample bits on synced SCL rising edges, MSB first, and SHALL change its SDA drive only on synced SCL falling edges.
REQ-015 SHALL implement the states IDLE, DEV, ACK_DEV, ADDR_H, ACK_H, ADDR_L, ACK_L, WDATA, ACK_W, RDATA, MACK and WAIT_STOP.
REQ-016 SHALL, on START in any state (including a repeated START), clear the bit counter and enter DEV.
REQ-017 SHALL, on STOP in any state, release SDA, deassert busy and enter IDLE.
REQ-018 In DEV, after 8 bits: if bits[7:1]==DEV_ID, SHALL go to ACK_DEV and set busy; otherwise SHALL go to WAIT_STOP with SDA released (NACK), no strobes and busy low.
REQ-019 In each ACK state, SHALL drive SDA low from the SCL falling edge after the 8th bit through the SCL falling edge after the 9th bit, then release it.
REQ-020 For a write (R/W=0), SHALL sequence ADDR_H -> ACK_H -> ADDR_L -> ACK_L, with reg_addr updated to {high,low} at the end of ACK_L.
REQ-021 In WDATA, on the 8th rising edge SHALL pulse reg_wr for 1 cycle with reg_wdata set to the byte and reg_addr unchanged, then ACK, increment reg_addr (wrapping 16'hFFFF -> 16'h0000) and return to WDATA.
REQ-022 For a read (R/W=1), SHALL pulse reg_rd on the rising edge of the ACK_DEV 9th clock, capture reg_rdata on the next cycle and drive its MSB at the following SCL falling edge.
REQ-023 In RDATA, SHALL drive the 8 bits, then release SDA for MACK. On master ACK (SDA=0) SHALL increment reg_addr, pulse reg_rd and continue in RDATA. On NACK SHALL go to WAIT_STOP.
REQ-024 SHALL keep reg_addr across transactions, so a write of address only, then a repeated START with read, reads that address.
REQ-025 SHALL NOT pulse reg_wr or reg_rd in IDLE or WAIT_STOP, or for a partial byte aborted by START or STOP.
REQ-026 SHALL, when START and STOP are detected in the same cycle (glitch), treat the event as STOP.
REQ-027 SHALL never drive SDA high; SDA SHALL be Z except during ACK slots and read 0-bits.

Reset
REQ-028 On s_rst=1 at a sclk edge, the block SHALL enter IDLE, release SDA, and clear reg_addr=0, reg_wr=0, reg_wdata=0, reg_rd=0, busy=0 and the synchronizers to 1.
REQ-029 Reset mid-transaction SHALL release SDA within 1 cycle and ignore the bus until the next START.

Verification
REQ-030 Write test: START, 0x78, 0x30, 0x08, 0x82, STOP -> 4 ACKs, one reg_wr with reg_addr=0x3008 and reg_wdata=0x82, busy low after STOP.
REQ-031 Sequential write test: START, 0x78, 0x47, 0x40, 0x11, 0x22, STOP -> reg_wr at 0x4740 (data 0x11) then at 0x4741 (data 0x22).
REQ-032 Random read test: write address 0x300A, repeated START, 0x79, with reg_rdata=0x56 and master NACK -> bits 0,1,0,1,0,1,1,0 on SDA, then WAIT_STOP.
REQ-033 Wrong ID test: START, 0x42, ... -> no ACK, no strobes, busy stays 0.
REQ-034 Abort test: STOP after ADDR_H, and separately s_rst during RDATA -> IDLE, SDA=Z, no reg_wr, reg_addr unchanged (or 0 after reset).
REQ-035 Wrap test: sequential write starting at 0xFFFF -> the second reg_wr is at 0x0000.
